div2: RTL and testbench

Iterative signed fixed-point divider for `t2_fxd_t` operands, the inverse operation of the `mul2` fixed-point multiplier in the quadra datapath. It computes y = (x1 << T2_F) / x2 with quotient truncation toward zero. It uses one restoring-division step per clock and saturates on overflow and divide-by-zero. Operands enter and results leave through valid/ready handshakes so the block can sit between pipelined quadra stages.

---
 rtl/div2.sv | 142 ++++++++++++++
 tb/tb_div2.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div2.sv
// Iterative signed fixed-point divider: y = (x1 << T2_F) / x2, truncated toward zero.
// Computes one restoring-division step per clock and saturates on overflow and on a zero divisor.
package quadra_pkg;
  localparam int T2_W = 16;
  localparam int T2_F = 8;
  typedef logic signed [T2_W-1:0] t2_fxd_t;
endpackage

module div2
  import quadra_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  output logic    in_ready,
  input  t2_fxd_t x1,
  input  t2_fxd_t x2,
  output logic    out_valid,
  input  logic    out_ready,
  output t2_fxd_t y,
  output logic    div0,
  output logic    ovf
);

  localparam int ITER  = T2_W + T2_F;
  localparam int CNT_W = $clog2(ITER);

  localparam t2_fxd_t MAX_VAL = {1'b0, {(T2_W-1){1'b1}}};
  localparam t2_fxd_t MIN_VAL = {1'b1, {(T2_W-1){1'b0}}};

  // Bit 0 drives in_ready and bit 1 drives out_valid. Both handshake outputs therefore come straight from flops.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    BUSY = 2'b00,
    DONE = 2'b10
  } state_t;

  state_t             state, state_next;
  logic [T2_W:0]      rem;
  logic [ITER-1:0]    quo;
  logic [ITER-1:0]    dvd;
  logic [T2_W-1:0]    ax2;
  logic [CNT_W-1:0]   cnt;
  logic               sign, x1_neg, zero;

  logic [T2_W-1:0]    ax1_in, ax2_in;
  logic [T2_W:0]      rem_sh, rem_step;
  logic [ITER-1:0]    quo_step;
  logic               q_bit, last, hi_ovf;
  logic [T2_W-1:0]    mag;
  t2_fxd_t            res_y;
  logic               res_div0, res_ovf;

  assign in_ready  = state[0];
  assign out_valid = state[1];

  assign ax1_in = x1[T2_W-1] ? T2_W'(-x1) : T2_W'(x1);
  assign ax2_in = x2[T2_W-1] ? T2_W'(-x2) : T2_W'(x2);

  // NOTE: every signal assigned in an always_comb gets a default at the top. A path that leaves a signal unassigned infers a latch.
  always_comb begin
    state_next = state;
    rem_sh     = {rem[T2_W-1:0], dvd[ITER-1]};
    q_bit      = (rem_sh >= {1'b0, ax2});
    rem_step   = q_bit ? rem_sh - {1'b0, ax2} : rem_sh;
    quo_step   = {quo[ITER-2:0], q_bit};
    last       = (cnt == CNT_W'(ITER - 1));

    unique case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Select the final result from the completed quotient magnitude.
  always_comb begin
    hi_ovf   = |quo_step[ITER-1:T2_W];
    mag      = quo_step[T2_W-1:0];
    res_y    = '0;
    res_div0 = 1'b0;
    res_ovf  = 1'b0;
    if (zero) begin
      res_y    = x1_neg ? MIN_VAL : MAX_VAL;
      res_div0 = 1'b1;
    end else if (!sign && (hi_ovf || mag[T2_W-1])) begin
      res_y   = MAX_VAL;
      res_ovf = 1'b1;
    end else if (sign && (hi_ovf || (mag[T2_W-1] && |mag[T2_W-2:0]))) begin
      res_y   = MIN_VAL;
      res_ovf = 1'b1;
    end else begin
      res_y = sign ? t2_fxd_t'(-mag) : t2_fxd_t'(mag);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      quo    <= '0;
      dvd    <= '0;
      ax2    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      x1_neg <= 1'b0;
      zero   <= 1'b0;
      y      <= '0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (in_valid) begin
          sign   <= x1[T2_W-1] ^ x2[T2_W-1];
          x1_neg <= x1[T2_W-1];
          zero   <= (x2 == '0);
          ax2    <= ax2_in;
          dvd    <= {ax1_in, {T2_F{1'b0}}};
          rem    <= '0;
          quo    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          rem <= rem_step;
          quo <= quo_step;
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            y    <= res_y;
            div0 <= res_div0;
            ovf  <= res_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div2.sv
// Directed bench for div2 with T2_W=16 and T2_F=8. The expected quotients are computed by hand.
// Latency is counted in cycles, with the cycle that presents the accepted operands as cycle 0.
module tb_div2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] x1, x2, y;
  logic        out_valid, out_ready, div0, ovf;

  int vectors     = 0;
  int miscompares = 0;

  div2 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .div0(div0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, ey;
    logic        ed0, eov;
  } vec_t;

  // Drives one operation and consumes its result. Returns lat = -1 if no result appears within the budget.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] ry, output logic rd0, output logic rov,
                        output int lat);
    int w;
    x1 = a; x2 = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 60) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!out_valid) lat = -1;
    ry = y; rd0 = div0; rov = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({in_ready, out_valid, y, div0, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b y=%h div0=%b ovf=%b, required 1 0 0000 0 0",
               in_ready, out_valid, y, div0, ovf);
    end
  endtask

  task automatic test_vec_table(input string name, input vec_t tv[4]);
    logic [15:0] ry; logic rd0, rov; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(tv[i].a, tv[i].b, ry, rd0, rov, lat);
      vectors++;
      if ({ry, rd0, rov} !== {tv[i].ey, tv[i].ed0, tv[i].eov}) begin
        miscompares++;
        $display("FAIL %s %h/%h: y=%h div0=%b ovf=%b, required y=%h div0=%b ovf=%b",
                 name, tv[i].a, tv[i].b, ry, rd0, rov, tv[i].ey, tv[i].ed0, tv[i].eov);
      end
      vectors++;
      if (lat !== 25) begin
        miscompares++;
        $display("FAIL %s_latency %h/%h: got %0d, required 25", name, tv[i].a, tv[i].b, lat);
      end
    end
  endtask

  task automatic test_arith;
    vec_t tv[4];
    tv[0] = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
    tv[1] = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
    tv[2] = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0};
    tv[3] = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0};
    test_vec_table("arith", tv);
  endtask

  task automatic test_saturation;
    vec_t tv[4];
    tv[0] = '{16'h6400, 16'h0080, 16'h7FFF, 1'b0, 1'b1};
    tv[1] = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
    tv[2] = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1};
    tv[3] = '{16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0};  // negative tiny quotient -> plain zero
    test_vec_table("saturation", tv);
  endtask

  task automatic test_div0;
    vec_t tv[4];
    tv[0] = '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0};
    tv[1] = '{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b0};
    tv[2] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0};
    tv[3] = '{16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0};
    test_vec_table("div0", tv);
  endtask

  task automatic test_backpressure;
    logic [15:0] ry; logic rd0, rov; int lat, bad;
    x1 = 16'h0300; x2 = 16'h0200; in_valid = 1'b1;
    @(negedge clk);
    x1 = 16'h0100; x2 = 16'h0300;  // pending operands, must wait for IDLE
    lat = 1;
    while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!out_valid || in_ready || y !== 16'h0180 || div0 || ovf) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0 || lat !== 25) begin
      miscompares++;
      $display("FAIL hold: %0d unstable cycles, latency %0d, required 0 and 25", bad, lat);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
    ry = y; rd0 = div0; rov = ovf;
    vectors++;
    if ({ry, rd0, rov} !== {16'h0055, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL pending_op: y=%h div0=%b ovf=%b, required 0055 0 0", ry, rd0, rov);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc[2]; logic [15:0] res[2];
    int n_acc = 0, n_res = 0, both = 0;
    x1 = 16'h0300; x2 = 16'h0200; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (n_acc == 1) begin x1 = 16'h0100; x2 = 16'h0300; end
      if (n_acc == 2) in_valid = 1'b0;
      if (in_ready && out_valid) both++;
      if (in_valid && in_ready && n_acc < 2) begin acc[n_acc] = c; n_acc++; end
      if (out_valid && n_res < 2) begin res[n_res] = y; n_res++; end
      @(negedge clk);
    end
    out_ready = 1'b0;
    vectors++;
    if (n_acc !== 2 || acc[1] - acc[0] !== 26) begin
      miscompares++;
      $display("FAIL interval: %0d accepts, spacing %0d, required 2 and 26", n_acc, acc[1] - acc[0]);
    end
    vectors++;
    if (n_res !== 2 || res[0] !== 16'h0180 || res[1] !== 16'h0055) begin
      miscompares++;
      $display("FAIL b2b_results: n=%0d y0=%h y1=%h, required 2 0180 0055", n_res, res[0], res[1]);
    end
    vectors++;
    if (both !== 0) begin
      miscompares++;
      $display("FAIL ready_valid_overlap: %0d cycles, required 0", both);
    end
  endtask

  task automatic test_reset_busy;
    logic [15:0] ry; logic rd0, rov; int lat, seen;
    x1 = 16'h6400; x2 = 16'h0080; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL aborted_result: out_valid for %0d cycles, required 0", seen);
    end
    run_op(16'hFD00, 16'h0200, ry, rd0, rov, lat);
    vectors++;
    if ({ry, rd0, rov} !== {16'hFE80, 1'b0, 1'b0} || lat !== 25) begin
      miscompares++;
      $display("FAIL after_reset: y=%h div0=%b ovf=%b lat=%0d, required FE80 0 0 25", ry, rd0, rov, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_arith();
    test_saturation();
    test_div0();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
